// File: rtl/lsu_dcache_fill_way_sel_if.sv
// Request, way-issue and fill-completion signal bundle for the dcache fill victim-way selector.
// The selector block uses the slave modport; the requester/fill datapath side uses master.
interface lsu_dcache_fill_way_sel_if #(
  parameter int IDX_W = 7
);
  logic             fill_req_vld;
  logic [IDX_W-1:0] fill_req_idx;
  logic [3:0]       fill_req_set_vld;
  logic             fill_req_rdy;

  logic             way_vld;
  logic [1:0]       way_sel;
  logic [IDX_W-1:0] way_idx;
  logic             way_rdy;

  logic             fill_done_vld;
  logic [IDX_W-1:0] fill_done_idx;
  logic [1:0]       fill_done_way;

  modport master (
    output fill_req_vld, fill_req_idx, fill_req_set_vld,
    input  fill_req_rdy,
    input  way_vld, way_sel, way_idx,
    output way_rdy,
    output fill_done_vld, fill_done_idx, fill_done_way
  );

  modport slave (
    input  fill_req_vld, fill_req_idx, fill_req_set_vld,
    output fill_req_rdy,
    output way_vld, way_sel, way_idx,
    input  way_rdy,
    input  fill_done_vld, fill_done_idx, fill_done_way
  );
endinterface

// File: rtl/lsu_dcache_fill_way_sel.sv
// Victim-way selector for dcache line fills: lowest invalid way, else LFSR way, skipping in-flight ways.
// Optional macro LSU_FILL_PEND_CHK_EN enables the pending-fill table; undefined, no in-flight exclusion.
module lsu_dcache_fill_way_sel #(
  parameter  int IDX_W = 7,
  parameter  int NPEND = 4,
  localparam int CNT_W = $clog2(NPEND + 1)
) (
  input  logic                    clk,
  input  logic                    arst_l,
  lsu_dcache_fill_way_sel_if.slave bus,
  input  logic [1:0]              lfsr_out,
  output logic                    lfsr_advance,
  output logic [CNT_W-1:0]        pend_cnt
);

  typedef enum logic [1:0] {IDLE, LOOKUP, ISSUE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] req_idx, req_idx_nxt;
  logic [3:0]       req_set_vld, req_set_vld_nxt;
  logic [1:0]       sel_way, sel_way_nxt;
  logic [3:0]       pmask;
  logic [3:0]       free_way;
  logic [1:0]       scan_way;
  logic             scan_found;
  logic             pend_full;
  logic             req_rdy;
  logic             alloc;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state       <= IDLE;
      req_idx     <= '0;
      req_set_vld <= '0;
      sel_way     <= '0;
    end else begin
      state       <= state_nxt;
      req_idx     <= req_idx_nxt;
      req_set_vld <= req_set_vld_nxt;
      sel_way     <= sel_way_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    req_idx_nxt     = req_idx;
    req_set_vld_nxt = req_set_vld;
    sel_way_nxt     = sel_way;
    lfsr_advance    = 1'b0;
    req_rdy         = 1'b0;
    bus.way_vld     = 1'b0;
    alloc           = 1'b0;
    free_way        = ~req_set_vld & ~pmask;
    scan_way        = 2'd0;
    scan_found      = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = arst_l & ~pend_full;
        if (bus.fill_req_vld && req_rdy) begin
          req_idx_nxt     = bus.fill_req_idx;
          req_set_vld_nxt = bus.fill_req_set_vld;
          state_nxt       = LOOKUP;
        end
      end
      LOOKUP: begin
        // All ways in flight: wait here for a completion to free one.
        if (|free_way) begin
          for (int w = 3; w >= 0; w--) begin
            if (free_way[w]) sel_way_nxt = 2'(w);
          end
          state_nxt = ISSUE;
        end else if (~&pmask) begin
          for (int k = 0; k < 4; k++) begin
            scan_way = lfsr_out + 2'(k);
            if (!scan_found && !pmask[scan_way]) begin
              sel_way_nxt = scan_way;
              scan_found  = 1'b1;
            end
          end
          lfsr_advance = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        bus.way_vld = 1'b1;
        if (bus.way_rdy) begin
          alloc     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.fill_req_rdy = req_rdy;
  assign bus.way_sel      = sel_way;
  assign bus.way_idx      = req_idx;

`ifdef LSU_FILL_PEND_CHK_EN
  logic [NPEND-1:0] pend_vld;
  logic [IDX_W-1:0] pend_idx [NPEND];
  logic [1:0]       pend_way [NPEND];
  logic [NPEND-1:0] alloc_oh;

  always_comb begin
    pmask    = '0;
    alloc_oh = '0;
    pend_cnt = '0;
    for (int i = 0; i < NPEND; i++) begin
      if (pend_vld[i] && pend_idx[i] == req_idx) pmask[pend_way[i]] = 1'b1;
      pend_cnt = pend_cnt + CNT_W'(pend_vld[i]);
    end
    for (int i = NPEND - 1; i >= 0; i--) begin
      if (!pend_vld[i]) alloc_oh = NPEND'(1) << i;
    end
  end

  assign pend_full = (pend_cnt == CNT_W'(NPEND));

  // Allocation uses the free vector before this cycle's completion clears.
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      pend_vld <= '0;
      for (int i = 0; i < NPEND; i++) begin
        pend_idx[i] <= '0;
        pend_way[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPEND; i++) begin
        if (alloc && alloc_oh[i]) begin
          pend_vld[i] <= 1'b1;
          pend_idx[i] <= req_idx;
          pend_way[i] <= sel_way;
        end else if (bus.fill_done_vld && pend_vld[i] &&
                     pend_idx[i] == bus.fill_done_idx &&
                     pend_way[i] == bus.fill_done_way) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end
`else
  logic unused_done;
  assign unused_done = ^{bus.fill_done_vld, bus.fill_done_idx, bus.fill_done_way, alloc};
  assign pmask       = '0;
  assign pend_cnt    = '0;
  assign pend_full   = 1'b0;
`endif

endmodule

// File: doc/lsu_dcache_fill_way_sel.md
Name: lsu_dcache_fill_way_sel

Overview:
- Downstream consumer of the dcache replacement LFSR; picks the victim way for each dcache line fill.
- Chooses the lowest invalid way of the indexed set. If all ways are valid, uses the LFSR's 2-bit random way. Ways with a fill already in flight to the same set are never chosen.
- Tracks outstanding fills in a small pending table. Drives the LFSR's advance input and hands the chosen (index, way) to the fill datapath via a valid/ready handshake.

Parameters:
- IDX_W, 7, dcache set-index width.
- NPEND, 4, pending-fill table entries (2..8).

Ports:
- clk  input  1  core clock
- arst_l  input  1  asynchronous active-low reset
- fill_req_vld  input  1  fill request valid
- fill_req_idx  input  IDX_W  set index of the fill
- fill_req_set_vld  input  4  valid bits of ways 3..0 of the indexed set, sampled with the request
- fill_req_rdy  output  1  block can accept a request
- lfsr_out  input  2  random way from the replacement LFSR
- lfsr_advance  output  1  one-cycle pulse; steps the LFSR
- way_vld  output  1  chosen way valid
- way_sel  output  2  chosen way
- way_idx  output  IDX_W  set index belonging to way_sel
- way_rdy  input  1  fill datapath accepts way_sel
- fill_done_vld  input  1  a fill completed
- fill_done_idx  input  IDX_W  index of the completed fill
- fill_done_way  input  2  way of the completed fill
- pend_cnt  output  clog2(NPEND+1)  occupied pending entries

Behaviour:
- Reset (arst_l=0, asynchronous):
  - FSM goes to IDLE and all pending entries are cleared.
  - way_vld, lfsr_advance, fill_req_rdy and pend_cnt are 0; way_sel and way_idx are 0.
  - Reset mid-operation drops the in-flight request with no allocation.
- FSM states IDLE, LOOKUP, ISSUE:
  - IDLE: fill_req_rdy = (pend_cnt != NPEND). On fill_req_vld & fill_req_rdy, register idx and set_vld, then go to LOOKUP.
  - LOOKUP: compute pmask[3:0], with bit w set when a valid pending entry matches (idx, w).
    - If (~set_vld & ~pmask) != 0: way_sel = lowest set bit, no advance, go to ISSUE.
    - Else if ~pmask != 0: way_sel = lfsr_out if that bit is clear in pmask, otherwise the first clear bit scanning upward mod 4 from lfsr_out. Pulse lfsr_advance for this cycle and go to ISSUE.
    - Else (all 4 ways pending): stay in LOOKUP with no advance and re-evaluate each cycle until a matching fill_done frees a way.
  - ISSUE: way_vld=1; way_sel and way_idx are held stable until way_rdy. On way_vld & way_rdy, allocate the lowest free pending entry with (idx, way_sel) and return to IDLE.
- Latency: way_vld asserts 2 cycles after request acceptance, minimum. fill_req_rdy is 0 in LOOKUP and ISSUE, so back-to-back requests are 3 cycles apart, minimum.
- Pending table:
  - fill_done_vld clears every valid entry matching (idx, way).
  - A done with no match is ignored.
  - pmask uses registered table state; a same-cycle done is not forwarded into LOOKUP.
  - Simultaneous allocate and done: both take effect. Allocation picks from the free vector before that cycle's clear.
  - pend_cnt always equals the number of valid entries.
- lfsr_advance pulses at most once per request and never outside LOOKUP.

Optional Feature:
- Macro: LSU_FILL_PEND_CHK_EN.
- Defined: pending table and pmask exclusion as specified above.
- Undefined:
  - No table; pmask is treated as 0 and pend_cnt is tied to 0.
  - fill_req_rdy is 1 whenever in IDLE.
  - fill_done_* inputs are ignored.
  - LOOKUP always exits to ISSUE in one cycle.

Test Plan:
- Reset then request idx=0x05, set_vld=4'b1011 -> way_vld 2 cycles after acceptance, way_sel=2, way_idx=0x05, no lfsr_advance.
- set_vld=4'b1111, lfsr_out=2'b01, table empty -> way_sel=1, exactly one lfsr_advance pulse, in LOOKUP.
- Pending (0x05,1), then request idx=0x05, set_vld=4'b1111, lfsr_out=1 -> way_sel=2; lfsr_advance pulses.
- Fill 4 ways of idx=0x10 with NPEND=4, then request idx=0x10 -> fill_req_rdy=0 while pend_cnt=4. Issue fill_done (0x10,3) -> rdy returns; the new request selects way 3.
- Hold way_rdy=0 for 5 cycles in ISSUE -> way_vld/way_sel/way_idx stable. Assert arst_l=0 mid-ISSUE -> way_vld=0 immediately, pend_cnt=0.
- fill_done (0x05,2) in the same cycle as an allocate handshake for (0x07,0) -> pend_cnt unchanged, and the table holds (0x07,0) but not (0x05,2).
